// File: rtl/data_memory_responder.sv
// Load/store responder over a word-organised little-endian RAM with byte/half/word access.
// Word-spanning accesses take a two-cycle split unless MISALIGNED_TRAP_EN is defined, which traps them instead.
module data_memory_responder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    IDLE,
    SECOND
  } state_e;

  state_e state_q, state_d;

  // Split-access context carried from the first to the second cycle.
  logic [ADDR_WIDTH-1:0] hi_word_q, hi_word_d;
  logic [3:0]            hi_be_q, hi_be_d;
  logic [31:0]           hi_wd_q, hi_wd_d;
  logic                  write_q, write_d;
  logic [31:0]           lo_rdata_q, lo_rdata_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;

  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_fault_q, resp_fault_d;

  logic [ADDR_WIDTH-1:0] req_word;
  logic [1:0]            req_off;
  logic [3:0]            size_mask;
  logic [7:0]            req_be;
  logic [63:0]           req_wd64;
  logic                  req_span;
  logic                  accept;
  logic                  unused_addr_hi;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wd;
  logic [31:0]           mem_rd;

  // Shift the two-word window down to the access offset, then extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [63:0] win, input logic [1:0] off,
                                              input logic [1:0] size, input logic sgn);
    logic [31:0] sh;
    sh = 32'(win >> {off, 3'b000});
    unique case (size)
      2'b00:   return {{24{sgn & sh[7]}}, sh[7:0]};
      2'b01:   return {{16{sgn & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign req_word       = req_address[ADDR_WIDTH+1:2];
  assign req_off        = req_address[1:0];
  assign unused_addr_hi = ^req_address[31:ADDR_WIDTH+2];

  always_comb begin
    unique case (req_size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  // Byte lanes 7..4 of the window belong to the following word.
  assign req_be   = {4'b0000, size_mask} << req_off;
  assign req_wd64 = {32'b0, req_wdata} << {req_off, 3'b000};
  assign req_span = |req_be[7:4];
  assign accept   = req_valid && (state_q == IDLE) && !reset;

  assign mem_rd = mem[mem_addr];

  always_comb begin
    state_d      = state_q;
    hi_word_d    = hi_word_q;
    hi_be_d      = hi_be_q;
    hi_wd_d      = hi_wd_q;
    write_d      = write_q;
    lo_rdata_d   = lo_rdata_q;
    off_d        = off_q;
    size_d       = size_q;
    signed_d     = signed_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = 1'b0;
    mem_addr     = req_word;
    mem_we       = 1'b0;
    mem_be       = 4'b0000;
    mem_wd       = 32'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_span) begin
`ifdef MISALIGNED_TRAP_EN
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_rdata_d = 32'b0;
`else
            mem_we     = req_write;
            mem_be     = req_be[3:0];
            mem_wd     = req_wd64[31:0];
            hi_word_d  = req_word + ADDR_WIDTH'(1);
            hi_be_d    = req_be[7:4];
            hi_wd_d    = req_wd64[63:32];
            write_d    = req_write;
            lo_rdata_d = mem_rd;
            off_d      = req_off;
            size_d     = req_size;
            signed_d   = req_signed;
            state_d    = SECOND;
`endif
          end else begin
            mem_we       = req_write;
            mem_be       = req_be[3:0];
            mem_wd       = req_wd64[31:0];
            resp_valid_d = 1'b1;
            resp_rdata_d = req_write ? 32'b0
                                     : load_extend({32'b0, mem_rd}, req_off, req_size, req_signed);
          end
        end
      end
      SECOND: begin
        mem_addr     = hi_word_q;
        mem_we       = write_q;
        mem_be       = hi_be_q;
        mem_wd       = hi_wd_q;
        resp_valid_d = 1'b1;
        resp_rdata_d = write_q ? 32'b0
                               : load_extend({mem_rd, lo_rdata_q}, off_q, size_q, signed_q);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A reset during the split drops the second half; the first half is already committed.
    if (reset) mem_we = 1'b0;
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'b0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  // Split context is only consumed in SECOND, which is always entered with fresh values.
  always_ff @(posedge clock) begin
    hi_word_q  <= hi_word_d;
    hi_be_q    <= hi_be_d;
    hi_wd_q    <= hi_wd_d;
    write_q    <= write_d;
    lo_rdata_q <= lo_rdata_d;
    off_q      <= off_d;
    size_q     <= size_d;
    signed_q   <= signed_d;
  end

  // NOTE: the RAM array has no reset so it maps onto block/distributed RAM.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wd[8*b +: 8];
      end
    end
  end

  assign busy       = (state_q == SECOND);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed cases plus randomized traffic
// compared against a byte-array reference model of the RAM.
module tb_data_memory_responder;

  localparam int AW        = 4;
  localparam int MEM_BYTES = 4 * (2 ** AW);

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata = 32'b0;
  logic [7:0]  ref_mem [MEM_BYTES];

`ifdef MISALIGNED_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  data_memory_responder #(.ADDR_WIDTH(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .busy        (busy),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_fault  (resp_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int byte_idx(input logic [31:0] a, input int i);
    return int'((a + 32'(i)) % 32'(MEM_BYTES));
  endfunction

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    int n;
    n = size_bytes(sz);
    v = 32'b0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[byte_idx(a, i)];
    if (sg && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (sg && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // One request; checks timing, busy, data and fault; leaves the bench in the response cycle.
  task automatic access(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input bit junk);
    int          n;
    bit          span;
    bit          exp_fault;
    logic [31:0] exp;
    n         = size_bytes(sz);
    span      = (int'(addr[1:0]) + n) > 4;
    exp_fault = TRAP && span;
    exp       = 32'b0;
    if (!exp_fault) begin
      if (wr) begin
        for (int i = 0; i < n; i++) ref_mem[byte_idx(addr, i)] = wd[8*i +: 8];
      end else begin
        exp = model_load(addr, sz, sg);
      end
    end
    req_valid   = 1'b1;
    req_write   = wr;
    req_size    = sz;
    req_signed  = sg;
    req_address = addr;
    req_wdata   = wd;
    @(posedge clock); #1;
    req_valid = 1'b0;
    if (span && !TRAP) begin
      check("split_busy", busy, 1'b1);
      check("split_no_early_resp", resp_valid, 1'b0);
      if (junk) begin
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_size    = 2'b10;
        req_address = addr ^ 32'h4;
        req_wdata   = $urandom;
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
    end
    check("resp_valid", resp_valid, 1'b1);
    check("resp_busy_low", busy, 1'b0);
    check("resp_rdata", resp_rdata, exp);
    check("resp_fault", resp_fault, exp_fault);
    last_rdata = exp;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clock); #1;
    check("idle_resp_valid", resp_valid, 1'b0);
    check("idle_fault", resp_fault, 1'b0);
    check("idle_rdata_hold", resp_rdata, last_rdata);
    check("idle_busy", busy, 1'b0);
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_size    = 2'b00;
    req_signed  = 1'b0;
    req_address = 32'b0;
    req_wdata   = 32'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_resp_valid", resp_valid, 1'b0);
    check("reset_rdata", resp_rdata, 32'b0);
    check("reset_fault", resp_fault, 1'b0);
    reset = 1'b0;

    // Give every word a known value so loads never see uninitialised RAM.
    for (int w = 0; w < 2 ** AW; w++) access(1'b1, 2'b10, 1'b0, 32'(4 * w), $urandom, 1'b0);
    idle();

    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    check("t2_word", resp_rdata, 32'hDEADBEEF);
    access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);
    check("t3_byte_signed", resp_rdata, 32'hFFFFFFDE);
    access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0);
    check("t3_byte_unsigned", resp_rdata, 32'h000000DE);
    access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0);
    check("t3_half_signed", resp_rdata, 32'hFFFFDEAD);
    access(1'b1, 2'b00, 1'b0, 32'h11, 32'h55, 1'b0);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    check("t4_neighbours", resp_rdata, 32'hDEAD55EF);

    access(1'b1, 2'b10, 1'b0, 32'h22, 32'h11223344, 1'b0);
    access(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1'b0);
    access(1'b0, 2'b01, 1'b0, 32'h24, 32'h0, 1'b0);
`ifndef MISALIGNED_TRAP_EN
    check("t5_half_hi", resp_rdata, 32'h00001122);
`endif
    access(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1'b0);

    // Spanning load with a competing request held during busy, then confirm no extra response.
    access(1'b0, 2'b10, 1'b1, 32'h23, 32'h0, 1'b1);
    idle();

    // Top word wraps to word 0.
    access(1'b1, 2'b10, 1'b0, 32'h3E, 32'hCAFEF00D, 1'b0);
    access(1'b0, 2'b10, 1'b0, 32'h3E, 32'h0, 1'b0);
`ifndef MISALIGNED_TRAP_EN
    check("wrap_word", resp_rdata, 32'hCAFEF00D);
`endif
    access(1'b0, 2'b01, 1'b1, 32'h00, 32'h0, 1'b0);
    access(1'b0, 2'b11, 1'b0, 32'hFFFF_FFC4, 32'h0, 1'b0);

    for (int k = 0; k < 400; k++) begin
      logic wr;
      bit   junk;
      wr   = 1'($urandom_range(0, 1));
      junk = ($urandom_range(0, 3) == 0);
      access(wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom, junk);
      if (junk || $urandom_range(0, 4) == 0) idle();
    end

    // Reset in the middle of a spanning store: only the first-half bytes may land.
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_size    = 2'b10;
    req_signed  = 1'b0;
    req_address = 32'h1D;
    req_wdata   = 32'hAABBCCDD;
    if (!TRAP) begin
      ref_mem[byte_idx(32'h1D, 0)] = 8'hDD;
      ref_mem[byte_idx(32'h1D, 1)] = 8'hCC;
      ref_mem[byte_idx(32'h1D, 2)] = 8'hBB;
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("rst_pre_busy", busy, !TRAP);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_resp_valid", resp_valid, 1'b0);
    check("rst_mid_rdata", resp_rdata, 32'b0);
    check("rst_mid_fault", resp_fault, 1'b0);
    reset      = 1'b0;
    last_rdata = 32'b0;
    idle();
    access(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, 1'b0);
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
